// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad path: key codes produced by the keypad
// decoder, the blank code shown by the 7-segment driver, and the state
// encoding of the number-entry buffer.
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int         KEY_W         = 5;

    localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
    localparam logic [4:0] KEY_BACKSPACE = 5'd10;
    localparam logic [4:0] KEY_CLEAR     = 5'd11;
    localparam logic [4:0] KEY_ENTER     = 5'd14;
    localparam logic [4:0] KEY_BLANK     = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } kb_state_e;

    function automatic logic is_digit(input logic [4:0] code);
        return (code <= KEY_DIGIT_MAX);
    endfunction

    // Anything that is not a decimal digit (blank slots in particular)
    // contributes zero to the converted value.
    function automatic logic [3:0] digit_value(input logic [4:0] code);
        return is_digit(code) ? code[3:0] : 4'd0;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
// Iterative Horner converter: turns N_DIGITS decimal key codes into a binary
// value, one digit per cycle, most significant slot first.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      load: acc <- 0, idx <- N_DIGITS-1, begin iterating next cycle
//   digits_in  digit slots, [0] = units; must stay stable while iterating
//   done       high in the last iteration cycle; value is final from the
//              following cycle on
//   value      accumulated binary value
//
// Latency: start sampled at edge t, iterations on edges t+1 .. t+N_DIGITS,
// value final in cycle t+N_DIGITS+1.
// -----------------------------------------------------------------------------
module bcd_to_bin_seq
    import keypad_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int ACC_W    = $clog2(10 ** N_DIGITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [N_DIGITS-1:0][KEY_W-1:0] digits_in,
    output logic                         done,
    output logic [ACC_W-1:0]             value
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             run_q, run_d;

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        run_d = run_q;
        if (start) begin
            acc_d = '0;
            idx_d = IDX_W'(N_DIGITS - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            // The result never exceeds 10**N_DIGITS-1, so working at ACC_W
            // bits loses nothing.
            acc_d = ACC_W'((acc_q * ACC_W'(10)) + ACC_W'(digit_value(digits_in[idx_q])));
            if (idx_q == '0) begin
                run_d = 1'b0;
            end else begin
                idx_d = idx_q - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            run_q <= run_d;
        end
    end

    assign done  = run_q && (idx_q == '0);
    assign value = acc_q;

endmodule

// File: rtl/keypad_number_buffer.sv
// -----------------------------------------------------------------------------
// keypad_number_buffer
// Collects decimal key presses into an N_DIGITS display buffer with
// backspace / clear / enter editing. Enter converts the buffer to binary,
// range-checks it against MAX_VALUE and commits it to the current colour
// channel, stepping through N_CHANNELS channels per frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | accepting key strobes, editing the digit buffer
//   CONV    | converter iterating over the frozen buffer, strobes dropped
//   DONE    | value final: commit or reject, clear buffer, back to IDLE
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   digito         key code (0-9 digit, 10 backspace, 11 clear, 14 enter)
//   cambio_digito  one-cycle strobe, digito valid
//   digits         display digits, [4:0] = units, 16 = blank
//   count, full    digits held / buffer full
//   busy           conversion in progress (CONV and DONE)
//   channel        channel the next commit targets
//   values         committed values, channel 0 at the LSBs
//   commit, error, frame_done   one-cycle result pulses
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module keypad_number_buffer
    import keypad_pkg::*;
#(
    parameter int N_DIGITS   = 3,
    parameter int N_CHANNELS = 3,
    parameter int MAX_VALUE  = 255,
    parameter int VAL_W      = $clog2(MAX_VALUE + 1)
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [4:0]                                        digito,
    input  logic                                              cambio_digito,
    output logic [5*N_DIGITS-1:0]                             digits,
    output logic [$clog2(N_DIGITS+1)-1:0]                     count,
    output logic                                              full,
    output logic                                              busy,
    output logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] channel,
    output logic [N_CHANNELS*VAL_W-1:0]                       values,
    output logic                                              commit,
    output logic                                              error,
    output logic                                              frame_done
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int ACC_W = $clog2(10 ** N_DIGITS);

    kb_state_e                           state_q, state_d;
    logic [N_DIGITS-1:0][KEY_W-1:0]      digits_q, digits_d;
    logic [CNT_W-1:0]                    count_q, count_d;
    logic                                full_q, full_d;
    logic                                busy_q, busy_d;
    logic [CH_W-1:0]                     channel_q, channel_d;
    logic [N_CHANNELS-1:0][VAL_W-1:0]    values_q, values_d;
    logic                                commit_q, commit_d;
    logic                                error_q, error_d;
    logic                                frame_done_q, frame_done_d;

    logic                                conv_start;
    logic                                conv_done;
    logic [ACC_W-1:0]                    conv_value;

    // The converter reads the live buffer; it cannot change while busy
    // because every strobe is dropped outside IDLE.
    bcd_to_bin_seq #(
        .N_DIGITS (N_DIGITS),
        .ACC_W    (ACC_W)
    ) u_conv (
        .clk       (clk),
        .reset     (reset),
        .start     (conv_start),
        .digits_in (digits_q),
        .done      (conv_done),
        .value     (conv_value)
    );

    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        count_d      = count_q;
        busy_d       = busy_q;
        channel_d    = channel_q;
        values_d     = values_q;
        commit_d     = 1'b0;
        error_d      = 1'b0;
        frame_done_d = 1'b0;
        conv_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cambio_digito) begin
                    if (is_digit(digito)) begin
                        // A digit on a full buffer is ignored rather than
                        // pushing the top digit out.
                        if (count_q != CNT_W'(N_DIGITS)) begin
                            for (int i = N_DIGITS - 1; i > 0; i--) begin
                                digits_d[i] = digits_q[i-1];
                            end
                            digits_d[0] = digito;
                            count_d     = count_q + CNT_W'(1);
                        end
                    end else if (digito == KEY_BACKSPACE) begin
                        if (count_q != '0) begin
                            for (int i = 0; i < N_DIGITS - 1; i++) begin
                                digits_d[i] = digits_q[i+1];
                            end
                            digits_d[N_DIGITS-1] = KEY_BLANK;
                            count_d              = count_q - CNT_W'(1);
                        end
                    end else if (digito == KEY_CLEAR) begin
                        digits_d = {N_DIGITS{KEY_BLANK}};
                        count_d  = '0;
                    end else if (digito == KEY_ENTER) begin
                        if (count_q != '0) begin
                            busy_d     = 1'b1;
                            conv_start = 1'b1;
                            state_d    = ST_CONV;
                        end
                    end
                end
            end

            ST_CONV: begin
                if (conv_done) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Full-width compare: an over-range entry must not wrap
                // into a legal value.
                if (32'(conv_value) <= 32'(MAX_VALUE)) begin
                    values_d[channel_q] = VAL_W'(conv_value);
                    commit_d            = 1'b1;
                    if (channel_q == CH_W'(N_CHANNELS - 1)) begin
                        channel_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        channel_d = channel_q + CH_W'(1);
                    end
                end else begin
                    error_d = 1'b1;
                end
                digits_d = {N_DIGITS{KEY_BLANK}};
                count_d  = '0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        full_d = (count_d == CNT_W'(N_DIGITS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            digits_q     <= {N_DIGITS{KEY_BLANK}};
            count_q      <= '0;
            full_q       <= 1'b0;
            busy_q       <= 1'b0;
            channel_q    <= '0;
            values_q     <= '0;
            commit_q     <= 1'b0;
            error_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            count_q      <= count_d;
            full_q       <= full_d;
            busy_q       <= busy_d;
            channel_q    <= channel_d;
            values_q     <= values_d;
            commit_q     <= commit_d;
            error_q      <= error_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digits     = digits_q;
    assign count      = count_q;
    assign full       = full_q;
    assign busy       = busy_q;
    assign channel    = channel_q;
    assign values     = values_q;
    assign commit     = commit_q;
    assign error      = error_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypad_number_buffer.sv
// -----------------------------------------------------------------------------
// tb_keypad_number_buffer
// Directed bench for keypad_number_buffer at its default parameters
// (3 digits, 3 channels, max 255). Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_number_buffer;
    import keypad_pkg::*;

    localparam logic [14:0] BLANK3 = {5'd16, 5'd16, 5'd16};

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  digito;
    logic        cambio_digito;
    logic [14:0] digits;
    logic [1:0]  count;
    logic        full;
    logic        busy;
    logic [1:0]  channel;
    logic [23:0] values;
    logic        commit;
    logic        error;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Per-entry observations gathered by enter_capture (cycle index relative
    // to the enter edge, 0 = never seen).
    int commit_at, error_at, frame_at;
    int commit_n, error_n, frame_n, busy_n;

    always #5 clk = ~clk;

    keypad_number_buffer #(
        .N_DIGITS   (3),
        .N_CHANNELS (3),
        .MAX_VALUE  (255)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .digito        (digito),
        .cambio_digito (cambio_digito),
        .digits        (digits),
        .count         (count),
        .full          (full),
        .busy          (busy),
        .channel       (channel),
        .values        (values),
        .commit        (commit),
        .error         (error),
        .frame_done    (frame_done)
    );

    task automatic do_reset();
        cambio_digito = 1'b0;
        digito        = 5'd31;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One-cycle strobe; returns at the falling edge of the cycle after the
    // sampling edge, where the effect is visible.
    task automatic press(input logic [4:0] code);
        @(negedge clk);
        digito        = code;
        cambio_digito = 1'b1;
        @(negedge clk);
        cambio_digito = 1'b0;
        digito        = 5'd31;
    endtask

    // Presses enter and records pulses/busy over cycles t+1 .. t+7.
    task automatic enter_capture();
        press(KEY_ENTER);
        commit_at = 0; error_at = 0; frame_at = 0;
        commit_n  = 0; error_n  = 0; frame_n  = 0; busy_n = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge clk);
            if (commit)     begin if (commit_at == 0) commit_at = k; commit_n++; end
            if (error)      begin if (error_at  == 0) error_at  = k; error_n++;  end
            if (frame_done) begin if (frame_at  == 0) frame_at  = k; frame_n++;  end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (digits !== BLANK3) begin errors++; $display("FAIL reset_digits: got %h expected %h", digits, BLANK3); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (channel !== 2'd0) begin errors++; $display("FAIL reset_channel: got %0d expected 0", channel); end
        checks++; if (values !== 24'd0) begin errors++; $display("FAIL reset_values: got %h expected 0", values); end
        checks++; if ({commit, error, frame_done} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {commit, error, frame_done}); end
    endtask

    task automatic test_commit_255();
        press(5'd2); press(5'd5); press(5'd5);
        checks++; if (digits !== {5'd2, 5'd5, 5'd5}) begin errors++; $display("FAIL c255_digits: got %h expected %h", digits, {5'd2, 5'd5, 5'd5}); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL c255_full: got %b expected 1", full); end
        enter_capture();
        checks++; if (commit_at !== 5) begin errors++; $display("FAIL c255_commit_cycle: got %0d expected 5", commit_at); end
        checks++; if (commit_n !== 1) begin errors++; $display("FAIL c255_commit_width: got %0d expected 1", commit_n); end
        checks++; if (busy_n !== 4) begin errors++; $display("FAIL c255_busy_cycles: got %0d expected 4", busy_n); end
        checks++; if (error_n !== 0) begin errors++; $display("FAIL c255_error: got %0d expected 0", error_n); end
        checks++; if (values[7:0] !== 8'd255) begin errors++; $display("FAIL c255_value: got %0d expected 255", values[7:0]); end
        checks++; if (channel !== 2'd1) begin errors++; $display("FAIL c255_channel: got %0d expected 1", channel); end
        checks++; if (digits !== BLANK3) begin errors++; $display("FAIL c255_blank: got %h expected %h", digits, BLANK3); end
    endtask

    task automatic test_full_backspace();
        press(5'd1); press(5'd2); press(5'd3); press(5'd4);
        checks++; if (digits !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL full_digits: got %h expected %h", digits, {5'd1, 5'd2, 5'd3}); end
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL full_count: got %0d expected 3", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
        press(KEY_BACKSPACE);
        checks++; if (digits !== {5'd16, 5'd1, 5'd2}) begin errors++; $display("FAIL bksp_digits: got %h expected %h", digits, {5'd16, 5'd1, 5'd2}); end
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bksp_count: got %0d expected 2", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL bksp_full: got %b expected 0", full); end
        press(KEY_CLEAR);
        checks++; if (digits !== BLANK3) begin errors++; $display("FAIL clear_digits: got %h expected %h", digits, BLANK3); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", count); end
        press(KEY_BACKSPACE);
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL bksp_empty_count: got %0d expected 0", count); end
    endtask

    task automatic test_over_range();
        press(5'd3); press(5'd0); press(5'd0);
        enter_capture();
        checks++; if (error_at !== 5) begin errors++; $display("FAIL ovr_error_cycle: got %0d expected 5", error_at); end
        checks++; if (commit_n !== 0) begin errors++; $display("FAIL ovr_commit: got %0d expected 0", commit_n); end
        checks++; if (values !== 24'h0000FF) begin errors++; $display("FAIL ovr_values: got %h expected 0000ff", values); end
        checks++; if (channel !== 2'd1) begin errors++; $display("FAIL ovr_channel: got %0d expected 1", channel); end
        checks++; if (digits !== BLANK3) begin errors++; $display("FAIL ovr_blank: got %h expected %h", digits, BLANK3); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL ovr_count: got %0d expected 0", count); end
    endtask

    task automatic test_frame();
        do_reset();
        press(5'd1); press(5'd0);
        enter_capture();
        checks++; if (commit_at !== 5) begin errors++; $display("FAIL frm1_commit: got %0d expected 5", commit_at); end
        checks++; if (frame_n !== 0) begin errors++; $display("FAIL frm1_frame: got %0d expected 0", frame_n); end
        checks++; if (channel !== 2'd1) begin errors++; $display("FAIL frm1_channel: got %0d expected 1", channel); end
        press(5'd2); press(5'd0);
        enter_capture();
        checks++; if (frame_n !== 0) begin errors++; $display("FAIL frm2_frame: got %0d expected 0", frame_n); end
        checks++; if (channel !== 2'd2) begin errors++; $display("FAIL frm2_channel: got %0d expected 2", channel); end
        press(5'd3); press(5'd0);
        enter_capture();
        checks++; if (commit_at !== 5) begin errors++; $display("FAIL frm3_commit: got %0d expected 5", commit_at); end
        checks++; if (frame_at !== 5) begin errors++; $display("FAIL frm3_frame_cycle: got %0d expected 5", frame_at); end
        checks++; if (frame_n !== 1) begin errors++; $display("FAIL frm3_frame_width: got %0d expected 1", frame_n); end
        checks++; if (channel !== 2'd0) begin errors++; $display("FAIL frm3_channel_wrap: got %0d expected 0", channel); end
        checks++; if (values !== 24'h1E140A) begin errors++; $display("FAIL frm3_values: got %h expected 1e140a", values); end
    endtask

    task automatic test_ignored();
        do_reset();
        enter_capture();
        checks++; if (commit_n + error_n + frame_n !== 0) begin errors++; $display("FAIL empty_enter_pulses: got %0d expected 0", commit_n + error_n + frame_n); end
        checks++; if (busy_n !== 0) begin errors++; $display("FAIL empty_enter_busy: got %0d expected 0", busy_n); end
        press(5'd13);
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL other_code_count: got %0d expected 0", count); end
        press(5'd4); press(5'd2);
        press(KEY_ENTER);                 // now in cycle t+1
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL conv_busy: got %b expected 1", busy); end
        press(5'd7);                      // sampled at edge t+2, in CONV; now in cycle t+3
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL conv_drop_count: got %0d expected 2", count); end
        checks++; if (digits !== {5'd16, 5'd4, 5'd2}) begin errors++; $display("FAIL conv_drop_digits: got %h expected %h", digits, {5'd16, 5'd4, 5'd2}); end
        repeat (2) @(negedge clk);        // cycle t+5
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL conv_drop_commit: got %b expected 1", commit); end
        checks++; if (values[7:0] !== 8'd42) begin errors++; $display("FAIL conv_drop_value: got %0d expected 42", values[7:0]); end
        @(negedge clk);
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL conv_drop_after_count: got %0d expected 0", count); end
    endtask

    task automatic test_reset_mid_conv();
        int pulses;
        do_reset();
        press(5'd5);
        enter_capture();
        checks++; if (channel !== 2'd1 || values !== 24'd5) begin errors++; $display("FAIL rmc_setup: got ch %0d val %h expected ch 1 val 000005", channel, values); end
        press(5'd9); press(5'd9);
        press(KEY_ENTER);                 // cycle t+1, first CONV cycle
        pulses = int'(commit) + int'(error) + int'(frame_done);
        @(negedge clk);                   // cycle t+2, second CONV cycle
        pulses += int'(commit) + int'(error) + int'(frame_done);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (digits !== BLANK3) begin errors++; $display("FAIL rmc_digits: got %h expected %h", digits, BLANK3); end
        checks++; if (count !== 2'd0 || full !== 1'b0) begin errors++; $display("FAIL rmc_count: got %0d/%b expected 0/0", count, full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy: got %b expected 0", busy); end
        checks++; if (channel !== 2'd0) begin errors++; $display("FAIL rmc_channel: got %0d expected 0", channel); end
        checks++; if (values !== 24'd0) begin errors++; $display("FAIL rmc_values: got %h expected 0", values); end
        for (int k = 0; k < 6; k++) begin
            pulses += int'(commit) + int'(error) + int'(frame_done);
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rmc_no_pulse: got %0d expected 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy_after: got %b expected 0", busy); end
    endtask

    initial begin
        reset         = 1'b1;
        cambio_digito = 1'b0;
        digito        = 5'd31;
        test_reset();
        test_commit_255();
        test_full_backspace();
        test_over_range();
        test_frame();
        test_ignored();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
